// File: rtl/benes_pkg.sv
// rtl/benes_pkg.sv - shared sizes, state encoding and helpers for the 8-port Benes looping router
package benes_pkg;

    localparam int N     = 8;
    localparam int LOG_N = 3;
    localparam int NSW   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INV  = 2'd1,
        WALK = 2'd2,
        DONE = 2'd3
    } state_e;

    // Index of the lowest switch whose flag is still clear; 0 when all are set.
    function automatic logic [1:0] lowest_unset(input logic [NSW-1:0] set_flags);
        lowest_unset = '0;
        for (int s = NSW - 1; s >= 0; s--) begin
            if (!set_flags[s]) lowest_unset = s[1:0];
        end
    endfunction

endpackage

// File: rtl/benes_inv.sv
// rtl/benes_inv.sv - inverse permutation table with duplicate-destination detection
module benes_inv
    import benes_pkg::*;
(
    input  logic             clk,      // rising-edge clock
    input  logic             rst,      // synchronous active-high reset
    input  logic             clr,      // clear table, written flags and duplicate flag
    input  logic             wr_en,    // write inv[wr_addr] = wr_data
    input  logic [LOG_N-1:0] wr_addr,  // output port being claimed
    input  logic [LOG_N-1:0] wr_data,  // input index claiming it
    input  logic [LOG_N-1:0] rd_addr,  // output port to look up
    output logic [LOG_N-1:0] rd_data,  // input index that reaches rd_addr
    output logic             dup       // duplicate seen so far, including this cycle's write
);

    logic [N-1:0][LOG_N-1:0] inv_q, inv_d;
    logic [N-1:0]            wr_q, wr_d;
    logic                    dup_q, dup_d;

    always_comb begin
        inv_d = inv_q;
        wr_d  = wr_q;
        dup_d = dup_q;
        if (clr) begin
            inv_d = '0;
            wr_d  = '0;
            dup_d = 1'b0;
        end else if (wr_en) begin
            inv_d[wr_addr] = wr_data;
            wr_d[wr_addr]  = 1'b1;
            if (wr_q[wr_addr]) dup_d = 1'b1;
        end
    end

    // Exposes the next-state value so the last INV cycle can act on its own duplicate.
    assign dup     = dup_d;
    assign rd_data = inv_q[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            inv_q <= '0;
            wr_q  <= '0;
            dup_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
            wr_q  <= wr_d;
            dup_q <= dup_d;
        end
    end

endmodule

// File: rtl/benes_loop_router.sv
// rtl/benes_loop_router.sv - looping-algorithm switch setter for the outer stages of an 8-port Benes network
module benes_loop_router
    import benes_pkg::*;
(
    input  logic        clk,      // rising-edge clock
    input  logic        rst,      // synchronous active-high reset
    input  logic        start,    // request pulse, honoured only in IDLE
    input  logic [23:0] dst,      // dst[3i+2:3i] = output port for input i
    output logic        busy,     // INV, WALK or DONE
    output logic        done,     // one-cycle completion pulse
    output logic        err,      // dst was not a permutation
    output logic [3:0]  in_sw,    // first-stage switches, 1 = crossed
    output logic [3:0]  out_sw,   // last-stage switches, 1 = upper feeds odd output
    output logic [7:0]  up_perm,  // upper 4x4 sub-permutation, 2 bits per input
    output logic [7:0]  lo_perm   // lower 4x4 sub-permutation, 2 bits per input
);

    state_e                  state_q, state_d;
    logic [N-1:0][LOG_N-1:0] dst_q, dst_d;
    logic [LOG_N-1:0]        cnt_q, cnt_d;
    logic [LOG_N-1:0]        a_q, a_d;
    logic [1:0]              loop_q, loop_d;
    logic [NSW-1:0]          set_q, set_d;
    logic [NSW-1:0]          in_sw_q, in_sw_d;
    logic [NSW-1:0]          out_sw_q, out_sw_d;
    logic [NSW-1:0][1:0]     up_q, up_d;
    logic [NSW-1:0][1:0]     lo_q, lo_d;
    logic                    err_q, err_d;

    logic                    inv_clr;
    logic                    inv_wr;
    logic                    inv_dup;
    logic [LOG_N-1:0]        inv_wr_addr;
    logic [LOG_N-1:0]        o;
    logic [LOG_N-1:0]        b;
    logic [NSW-1:0]          set_nx;
    logic [1:0]              ls;

    assign o           = dst_q[a_q];
    assign inv_wr      = (state_q == INV);
    assign inv_wr_addr = dst_q[cnt_q];

    // b is the input that must reach o's switch partner, so it rides the lower subnet.
    benes_inv u_inv (
        .clk     (clk),
        .rst     (rst),
        .clr     (inv_clr),
        .wr_en   (inv_wr),
        .wr_addr (inv_wr_addr),
        .wr_data (cnt_q),
        .rd_addr (o ^ 3'd1),
        .rd_data (b),
        .dup     (inv_dup)
    );

    always_comb begin
        state_d  = state_q;
        dst_d    = dst_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        loop_d   = loop_q;
        set_d    = set_q;
        in_sw_d  = in_sw_q;
        out_sw_d = out_sw_q;
        up_d     = up_q;
        lo_d     = lo_q;
        err_d    = err_q;
        inv_clr  = 1'b0;
        set_nx   = set_q;
        ls       = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dst_d    = dst;
                    cnt_d    = '0;
                    a_d      = '0;
                    loop_d   = '0;
                    set_d    = '0;
                    in_sw_d  = '0;
                    out_sw_d = '0;
                    up_d     = '0;
                    lo_d     = '0;
                    err_d    = 1'b0;
                    inv_clr  = 1'b1;
                    state_d  = INV;
                end
            end
            INV: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(N - 1)) begin
                    cnt_d = '0;
                    if (inv_dup) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        // Walk begins on input 0 with switch 0 straight.
                        set_d[0] = 1'b1;
                        state_d  = WALK;
                    end
                end
            end
            WALK: begin
                out_sw_d[o[2:1]] = o[0];
                in_sw_d[b[2:1]]  = ~b[0];
                up_d[a_q[2:1]]   = o[2:1];
                lo_d[b[2:1]]     = o[2:1];
                set_nx           = set_q | (4'b0001 << b[2:1]);
                set_d            = set_nx;
                if (b[2:1] == loop_q) begin
                    // Loop closed: open a new one on the lowest free switch, set straight.
                    ls     = lowest_unset(set_nx);
                    a_d    = {ls, 1'b0};
                    loop_d = ls;
                    if (!(&set_nx)) begin
                        in_sw_d[ls] = 1'b0;
                        set_d[ls]   = 1'b1;
                    end
                end else begin
                    a_d = b ^ 3'd1;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q[1:0] == 2'd3) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            dst_q    <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            loop_q   <= '0;
            set_q    <= '0;
            in_sw_q  <= '0;
            out_sw_q <= '0;
            up_q     <= '0;
            lo_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            loop_q   <= loop_d;
            set_q    <= set_d;
            in_sw_q  <= in_sw_d;
            out_sw_q <= out_sw_d;
            up_q     <= up_d;
            lo_q     <= lo_d;
            err_q    <= err_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign in_sw   = in_sw_q;
    assign out_sw  = out_sw_q;
    assign up_perm = up_q;
    assign lo_perm = lo_q;

endmodule

// File: doc/benes_loop_router.md
BENES_LOOP_ROUTER -- requirements
Module: benes_loop_router

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 start  in  1  request pulse; sampled only in IDLE.
REQ-004 dst  in  24  permutation; dst[3i+2:3i] is the output port reached by input i; captured on accepted start.
REQ-005 busy  out  1  high in INV, WALK and DONE states.
REQ-006 done  out  1  one-cycle completion pulse.
REQ-007 err  out  1  dst is not a permutation; valid with done, held until next accepted start.
REQ-008 in_sw  out  4  first-stage switch settings; bit s=1 means crossed (input 2s to lower subnet).
REQ-009 out_sw  out  4  last-stage switch settings; bit k=1 means upper subnet feeds output 2k+1.
REQ-010 up_perm  out  8  upper 4x4 sub-permutation; field [2s+1:2s] is the upper output index for upper input s.
REQ-011 lo_perm  out  8  lower 4x4 sub-permutation, same packing as up_perm.

Function
REQ-012 The FSM SHALL have four states: IDLE -> INV -> WALK -> DONE -> IDLE.
REQ-013 start in IDLE SHALL capture dst, clear all result registers and per-switch set flags, and enter INV; start in any other state SHALL be ignored.
REQ-014 INV SHALL last exactly 8 cycles; in cycle j it writes inv[dst[j]] = j and flags a duplicate if inv[dst[j]] was already written.
REQ-015 If a duplicate is flagged, INV SHALL go directly to DONE with err=1 and all result outputs zero.
REQ-016 WALK SHALL last exactly 4 cycles, each processing one input switch; the first current input is a=0, with in_sw[0]=0 marked set.
REQ-017 Each WALK cycle SHALL perform the following on current upper-going input a:
  - o=dst[a]; out_sw[o>>1]=o[0];
  - b=inv[o^1]; in_sw[b>>1]=~b[0]; mark switch b>>1 set;
  - up_perm[a>>1]=o>>1; lo_perm[b>>1]=(o^1)>>1.
REQ-018 Loop-close rule: if b>>1 equals the switch the current loop started on, the next a SHALL be 2*(lowest unset switch), and that switch SHALL be set straight (0) and marked set; otherwise the next a SHALL be b^1.
REQ-019 A two-input loop (b = a^1) SHALL close in the same cycle.
REQ-020 After the fourth WALK cycle the FSM SHALL enter DONE; done=1 for exactly that cycle, then IDLE.
REQ-021 With start sampled at cycle 0, done SHALL assert at cycle 13 (err=0) or cycle 9 (err=1).
REQ-022 Result outputs SHALL be registered and SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-023 rst SHALL force IDLE and clear busy, done, err, in_sw, out_sw, up_perm, lo_perm, the inverse table and the set flags to 0 on the next edge, including mid-INV and mid-WALK.
REQ-024 rst SHALL take priority over start in the same cycle.

Structure
REQ-025 Package benes_pkg SHALL hold N=8, LOG_N=3, NSW=4 and the state enum (IDLE, INV, WALK, DONE).
REQ-026 The inverse table and duplicate detection SHALL be a sub-module named benes_inv; the looping walk stays in benes_loop_router.

Verification
REQ-027 Identity (dst[i]=i) -> done at cycle 13, err=0, in_sw=0000, out_sw=0000, up_perm=lo_perm={3,2,1,0} packed (0xE4).
REQ-028 Reversal (dst[i]=7-i) -> in_sw=0000, out_sw=1111, up_perm=lo_perm={0,1,2,3} packed (0x1B).
REQ-029 Pair swap (dst={1,0,3,2,5,4,7,6}) -> in_sw=0000, out_sw=1111, up_perm=lo_perm=0xE4.
REQ-030 dst all zeros -> done at cycle 9 with err=1 and all result outputs 0.
REQ-031 start pulsed during WALK -> ignored; results match the first request.
REQ-032 rst asserted in WALK cycle 2 -> all outputs 0 on the next edge, IDLE; a new start then completes normally.
